// File: rtl/addsub_pkg.sv
// Shared definitions for the adder-subtractor result stage: flag bit positions and mode encodings.
package addsub_pkg;

  localparam int unsigned FLAGS_W = 4;
  localparam int unsigned FLG_C   = 0;
  localparam int unsigned FLG_Z   = 1;
  localparam int unsigned FLG_N   = 2;
  localparam int unsigned FLG_V   = 3;

  typedef enum logic {
    ModeAdd = 1'b0,
    ModeSub = 1'b1
  } addsub_mode_e;

endpackage

// File: rtl/addsub_result_fifo.sv
// Generic synchronous FIFO with async active-low reset and occupancy count.
module addsub_result_fifo #(
  parameter int unsigned DataW = 8,
  parameter int unsigned Depth = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [DataW-1:0]           data_i,
  input  logic                       pop_i,
  output logic [DataW-1:0]           data_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(Depth):0]     occupancy_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [DataW-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o     = (cnt_q == '0);
  assign full_o      = (cnt_q == CntW'(Depth));
  assign occupancy_o = cnt_q;
  assign data_o      = mem_q[rd_ptr_q];

  // Push into a full FIFO or pop from an empty one is dropped without side effects.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/addsub_result_stage.sv
// Registered consumer of adder-subtractor results: derives {V,N,Z,C}, buffers in a FIFO and
// counts signed overflows. Define ADDSUB_SAT_EN to saturate the result on overflow.
module addsub_result_stage
  import addsub_pkg::*;
#(
  parameter int unsigned W     = 4,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [W-1:0]              in_a,
  input  logic [W-1:0]              in_b,
  input  logic                      in_mode,
  input  logic [W-1:0]              in_sum,
  input  logic                      in_cout,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [W-1:0]              out_result,
  output logic [FLAGS_W-1:0]        out_flags,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic [CNT_W-1:0]          ovf_cnt
);

  logic               b_eff_msb;
  logic               flag_v, flag_c;
  logic [W-1:0]       result;
  logic [FLAGS_W-1:0] flags;
  logic               push, pop, fifo_empty, fifo_full;
  logic [CNT_W-1:0]   ovf_cnt_q, ovf_cnt_d;
  logic               unused_in;

  // Only the sign bits of the operands take part in overflow detection.
  assign unused_in = ^{in_a[W-2:0], in_b[W-2:0]};

  assign b_eff_msb = in_b[W-1] ^ in_mode;
  assign flag_c    = (in_mode == ModeSub) ? ~in_cout : in_cout;
  assign flag_v    = ~(in_a[W-1] ^ b_eff_msb) & (in_a[W-1] ^ in_sum[W-1]);

  always_comb begin
    result = in_sum;
`ifdef ADDSUB_SAT_EN
    if (flag_v) result = in_a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
  end

  always_comb begin
    flags        = '0;
    flags[FLG_C] = flag_c;
    flags[FLG_Z] = (result == '0);
    flags[FLG_N] = result[W-1];
    flags[FLG_V] = flag_v;
  end

  assign in_ready  = ~fifo_full;
  assign out_valid = ~fifo_empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  addsub_result_fifo #(
    .DataW (W + FLAGS_W),
    .Depth (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .data_i      ({flags, result}),
    .pop_i       (pop),
    .data_o      ({out_flags, out_result}),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .occupancy_o (occupancy)
  );

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (push && flag_v && !(&ovf_cnt_q)) ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_cnt_q <= '0;
    else        ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_cnt = ovf_cnt_q;

endmodule

// File: tb/tb_addsub_result_stage.sv
// Randomized and directed bench for addsub_result_stage against an arithmetic queue model.
module tb_addsub_result_stage;

  localparam int unsigned W     = 4;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 4;
  localparam int          OVF_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [3:0] flags;
    logic [3:0] result;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_a = '0;
  logic [W-1:0]     in_b = '0;
  logic             in_mode = 1'b0;
  logic [W-1:0]     in_sum = '0;
  logic             in_cout = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [W-1:0]     out_result;
  logic [3:0]       out_flags;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] ovf_cnt;

  int   n_vec = 0;
  int   n_err = 0;
  ent_t mq[$];
  int   m_ovf = 0;

  addsub_result_stage #(
    .W     (W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_mode    (in_mode),
    .in_sum     (in_sum),
    .in_cout    (in_cout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .occupancy  (occupancy),
    .ovf_cnt    (ovf_cnt)
  );

  always #5 clk = ~clk;

  // Upstream 4-bit adder-subtractor: subtract is a + ~b + 1.
  function automatic logic [4:0] adder(input logic [3:0] a, input logic [3:0] b, input logic m);
    if (m) return {1'b0, a} + {1'b0, ~b} + 5'd1;
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Reference: signed arithmetic on integers, overflow = out of [-8,7].
  function automatic ent_t ref_calc(input logic [3:0] a, input logic [3:0] b, input logic m);
    int sa, sb, r;
    logic v, c;
    logic [3:0] res;
    ent_t e;
    sa  = a[3] ? int'(a) - 16 : int'(a);
    sb  = b[3] ? int'(b) - 16 : int'(b);
    r   = m ? sa - sb : sa + sb;
    v   = (r > 7) || (r < -8);
    c   = m ? (a < b) : ((int'(a) + int'(b)) > 15);
    res = 4'(r);
`ifdef ADDSUB_SAT_EN
    if (v) res = a[3] ? 4'b1000 : 4'b0111;
`endif
    e.result = res;
    e.flags  = {v, res[3], (res == 4'd0), c};
    return e;
  endfunction

  // Drive one cycle and advance the model; returns at edge + 1.
  task automatic tick(input logic v, input logic [3:0] a, input logic [3:0] b, input logic m,
                      input logic r);
    logic [4:0] ab;
    logic push, pop;
    ent_t e;
    ab        = adder(a, b, m);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_mode   = m;
    in_sum    = ab[3:0];
    in_cout   = ab[4];
    out_ready = r;
    push = v && (mq.size() < DEPTH);
    pop  = r && (mq.size() > 0);
    @(posedge clk);
    #1;
    if (pop) void'(mq.pop_front());
    if (push) begin
      e = ref_calc(a, b, m);
      mq.push_back(e);
      if (e.flags[3] && m_ovf < OVF_MAX) m_ovf++;
    end
  endtask

  task automatic test_reset;
    #3;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || occupancy !== 2'd0 || ovf_cnt !== '0 ||
        out_result !== '0 || out_flags !== '0) begin
      n_err++;
      $display("FAIL reset: rdy=%b vld=%b occ=%0d ovf=%0d res=%h flg=%b, want 1 0 0 0 0 0000",
               in_ready, out_valid, occupancy, ovf_cnt, out_result, out_flags);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed;
    logic [3:0] want_res, want_flg;
`ifdef ADDSUB_SAT_EN
    want_res = 4'b0111; want_flg = 4'b1000;
`else
    want_res = 4'd8;    want_flg = 4'b1100;
`endif
    tick(1'b1, 4'd5, 4'd3, 1'b0, 1'b0);
    n_vec++;
    if (out_valid !== 1'b1 || out_result !== want_res || out_flags !== want_flg ||
        ovf_cnt !== 4'd1) begin
      n_err++;
      $display("FAIL add_5_3: vld=%b res=%h flg=%b ovf=%0d, want 1 %h %b 1",
               out_valid, out_result, out_flags, ovf_cnt, want_res, want_flg);
    end
    tick(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
    tick(1'b1, 4'd3, 4'd5, 1'b1, 1'b0);
    n_vec++;
    if (out_result !== 4'd14 || out_flags !== 4'b0101 || ovf_cnt !== 4'd1) begin
      n_err++;
      $display("FAIL sub_3_5: res=%0d flg=%b ovf=%0d, want 14 0101 1",
               out_result, out_flags, ovf_cnt);
    end
    tick(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
    tick(1'b1, 4'd7, 4'd7, 1'b1, 1'b0);
    n_vec++;
    if (out_result !== 4'd0 || out_flags !== 4'b0010) begin
      n_err++;
      $display("FAIL sub_7_7: res=%0d flg=%b, want 0 0010", out_result, out_flags);
    end
    tick(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
    n_vec++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      n_err++;
      $display("FAIL drain_directed: vld=%b occ=%0d, want 0 0", out_valid, occupancy);
    end
  endtask

  task automatic test_backpressure;
    tick(1'b1, 4'd1, 4'd1, 1'b0, 1'b0);
    tick(1'b1, 4'd2, 4'd2, 1'b0, 1'b0);
    n_vec++;
    if (in_ready !== 1'b0 || occupancy !== 2'd2) begin
      n_err++;
      $display("FAIL bp_full: rdy=%b occ=%0d, want 0 2", in_ready, occupancy);
    end
    tick(1'b1, 4'd3, 4'd1, 1'b0, 1'b0);
    n_vec++;
    if (occupancy !== 2'd2 || out_result !== 4'd2) begin
      n_err++;
      $display("FAIL bp_held: occ=%0d res=%0d, want 2 2", occupancy, out_result);
    end
    tick(1'b1, 4'd3, 4'd1, 1'b0, 1'b1);
    n_vec++;
    if (occupancy !== 2'd1 || out_result !== 4'd4 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_pop1: occ=%0d res=%0d rdy=%b, want 1 4 1", occupancy, out_result, in_ready);
    end
    tick(1'b1, 4'd3, 4'd1, 1'b0, 1'b1);
    n_vec++;
    if (occupancy !== 2'd1 || out_result !== 4'd4) begin
      n_err++;
      $display("FAIL bp_third_in: occ=%0d res=%0d, want 1 4", occupancy, out_result);
    end
    tick(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
    n_vec++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_drain: occ=%0d vld=%b, want 0 0", occupancy, out_valid);
    end
  endtask

  task automatic test_full_pop;
    tick(1'b1, 4'd1, 4'd2, 1'b0, 1'b0);
    tick(1'b1, 4'd6, 4'd1, 1'b1, 1'b0);
    tick(1'b1, 4'd9, 4'd4, 1'b0, 1'b1);
    n_vec++;
    if (occupancy !== 2'd1 || out_result !== 4'd5) begin
      n_err++;
      $display("FAIL full_pop_only: occ=%0d res=%0d, want 1 5", occupancy, out_result);
    end
    tick(1'b1, 4'd9, 4'd4, 1'b0, 1'b0);
    n_vec++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL full_push_next: occ=%0d rdy=%b, want 2 0", occupancy, in_ready);
    end
    tick(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
    n_vec++;
    if (out_result !== mq[0].result || out_flags !== mq[0].flags) begin
      n_err++;
      $display("FAIL full_order: res=%h flg=%b, want %h %b",
               out_result, out_flags, mq[0].result, mq[0].flags);
    end
    tick(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
  endtask

  task automatic test_ovf_sat;
    for (int i = 0; i < 20; i++) tick(1'b1, 4'd7, 4'd7, 1'b0, 1'b1);
    n_vec++;
    if (ovf_cnt !== CNT_W'(OVF_MAX) || int'(ovf_cnt) != m_ovf) begin
      n_err++;
      $display("FAIL ovf_saturate: ovf=%0d, want %0d", ovf_cnt, OVF_MAX);
    end
    tick(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
  endtask

  task automatic test_random;
    logic v, r, m;
    logic [3:0] a, b;
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      m = 1'($urandom);
      a = 4'($urandom);
      b = 4'($urandom);
      tick(v, a, b, m, r);
      n_vec++;
      if (in_ready !== (mq.size() < DEPTH) || out_valid !== (mq.size() > 0) ||
          int'(occupancy) != mq.size() || int'(ovf_cnt) != m_ovf) begin
        n_err++;
        $display("FAIL rand_ctl[%0d]: rdy=%b vld=%b occ=%0d ovf=%0d, want occ=%0d ovf=%0d",
                 i, in_ready, out_valid, occupancy, ovf_cnt, mq.size(), m_ovf);
      end
      if (mq.size() > 0) begin
        n_vec++;
        if (out_result !== mq[0].result || out_flags !== mq[0].flags) begin
          n_err++;
          $display("FAIL rand_data[%0d]: res=%h flg=%b, want %h %b",
                   i, out_result, out_flags, mq[0].result, mq[0].flags);
        end
      end
    end
    while (mq.size() > 0) tick(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_midstream;
    tick(1'b1, 4'd5, 4'd3, 1'b0, 1'b0);
    tick(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    mq.delete();
    m_ovf = 0;
    n_vec++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || ovf_cnt !== '0) begin
      n_err++;
      $display("FAIL async_reset: vld=%b occ=%0d ovf=%0d, want 0 0 0",
               out_valid, occupancy, ovf_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_ready: rdy=%b, want 1", in_ready);
    end
    tick(1'b1, 4'd3, 4'd5, 1'b1, 1'b0);
    n_vec++;
    if (out_valid !== 1'b1 || out_result !== 4'd14 || occupancy !== 2'd1) begin
      n_err++;
      $display("FAIL restart: vld=%b res=%0d occ=%0d, want 1 14 1",
               out_valid, out_result, occupancy);
    end
    tick(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_full_pop();
    test_ovf_sat();
    test_random();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, want completion before 200000");
    $fatal(1);
  end

endmodule
